// File: rtl/bsg_mul_iterative_scheduler.sv
// Round-robin front end sharing one iterative multiplier among els_p requesters.
// Optional performance counters are enabled by defining BSG_MUL_SCHED_PERF_CNT_EN.
//   state | meaning
//   eIDLE | accepting; cyclic-scan winner from rr_ptr_r drives the multiplier
//   eBUSY | one operation outstanding; result routed to tag_r until consumed
module bsg_mul_iterative_scheduler #(
  parameter  int els_p        = 4,
  parameter  int width_p      = 32,
  parameter  int full_sized_p = 1,
  localparam int res_w        = (full_sized_p != 0) ? 2*width_p : width_p,
  localparam int tag_w        = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic [els_p-1:0]         req_v_i,
  output logic [els_p-1:0]         req_ready_o,
  input  logic [els_p*width_p-1:0] req_opA_i,
  input  logic [els_p*width_p-1:0] req_opB_i,
  input  logic [els_p-1:0]         req_opA_signed_i,
  input  logic [els_p-1:0]         req_opB_signed_i,

  output logic [els_p-1:0]         res_v_o,
  output logic [res_w-1:0]         res_data_o,
  input  logic [els_p-1:0]         res_yumi_i,

  output logic                     mul_v_o,
  output logic [width_p-1:0]       mul_opA_o,
  output logic [width_p-1:0]       mul_opB_o,
  output logic                     mul_opA_signed_o,
  output logic                     mul_opB_signed_o,
  input  logic                     mul_ready_i,

  input  logic                     mul_v_i,
  input  logic [res_w-1:0]         mul_result_i,
  output logic                     mul_yumi_o
`ifdef BSG_MUL_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]              perf_ops_o,
  output logic [31:0]              perf_busy_o
`endif
);

  typedef enum logic {eIDLE, eBUSY} state_e;

  state_e           state_r, state_n;
  logic [tag_w-1:0] rr_ptr_r, rr_ptr_n;
  logic [tag_w-1:0] tag_r, tag_n;
  logic [tag_w-1:0] winner, cand;
  logic [tag_w:0]   scan_idx;
  logic             found;
  logic             any_v;

  assign any_v = |req_v_i;

  // Cyclic priority scan: first valid requester at or after rr_ptr_r.
  always_comb begin
    winner   = rr_ptr_r;
    found    = 1'b0;
    scan_idx = '0;
    cand     = '0;
    for (int k = 0; k < els_p; k++) begin
      scan_idx = {1'b0, rr_ptr_r} + (tag_w+1)'(k);
      if (scan_idx >= (tag_w+1)'(els_p))
        scan_idx = scan_idx - (tag_w+1)'(els_p);
      cand = scan_idx[tag_w-1:0];
      if (!found && req_v_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign mul_opA_o        = req_opA_i[winner*width_p +: width_p];
  assign mul_opB_o        = req_opB_i[winner*width_p +: width_p];
  assign mul_opA_signed_o = req_opA_signed_i[winner];
  assign mul_opB_signed_o = req_opB_signed_i[winner];
  assign res_data_o       = mul_result_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= eIDLE;
      rr_ptr_r <= '0;
      tag_r    <= '0;
    end else begin
      state_r  <= state_n;
      rr_ptr_r <= rr_ptr_n;
      tag_r    <= tag_n;
    end
  end

  always_comb begin
    state_n     = state_r;
    rr_ptr_n    = rr_ptr_r;
    tag_n       = tag_r;
    req_ready_o = '0;
    res_v_o     = '0;
    mul_v_o     = 1'b0;
    mul_yumi_o  = 1'b0;
    case (state_r)
      eIDLE: begin
        mul_v_o = any_v;
        if (any_v && mul_ready_i) begin
          req_ready_o[winner] = 1'b1;
          tag_n    = winner;
          rr_ptr_n = (winner == tag_w'(els_p-1)) ? '0 : winner + 1'b1;
          state_n  = eBUSY;
        end
      end
      eBUSY: begin
        res_v_o[tag_r] = mul_v_i;
        mul_yumi_o     = mul_v_i & res_yumi_i[tag_r];
        if (mul_v_i && res_yumi_i[tag_r])
          state_n = eIDLE;
      end
    endcase
    // Handshake outputs stay quiet for the whole reset pulse, not just after the edge.
    if (reset_i) begin
      req_ready_o = '0;
      res_v_o     = '0;
      mul_v_o     = 1'b0;
      mul_yumi_o  = 1'b0;
    end
  end

`ifdef BSG_MUL_SCHED_PERF_CNT_EN
  logic [31:0] perf_ops_r, perf_busy_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_ops_r  <= '0;
      perf_busy_r <= '0;
    end else begin
      if (mul_yumi_o && (perf_ops_r != '1))
        perf_ops_r <= perf_ops_r + 32'd1;
      if ((state_r == eBUSY) && (perf_busy_r != '1))
        perf_busy_r <= perf_busy_r + 32'd1;
    end
  end

  assign perf_ops_o  = perf_ops_r;
  assign perf_busy_o = perf_busy_r;
`endif

endmodule

// File: tb/tb_bsg_mul_iterative_scheduler.sv
// Bench for bsg_mul_iterative_scheduler: bench-side requesters and multiplier, a
// round-robin reference model, and a result scoreboard drained by a separate monitor.
module tb_bsg_mul_iterative_scheduler;

  localparam int els_lp = 4;
  localparam int w_lp   = 32;
  localparam int rw_lp  = 64;

  logic                     clk_i = 1'b0;
  logic                     reset_i;
  logic [els_lp-1:0]        req_v_i;
  logic [els_lp-1:0]        req_ready_o;
  logic [els_lp*w_lp-1:0]   req_opA_i, req_opB_i;
  logic [els_lp-1:0]        req_opA_signed_i, req_opB_signed_i;
  logic [els_lp-1:0]        res_v_o;
  logic [rw_lp-1:0]         res_data_o;
  logic [els_lp-1:0]        res_yumi_i;
  logic                     mul_v_o;
  logic [w_lp-1:0]          mul_opA_o, mul_opB_o;
  logic                     mul_opA_signed_o, mul_opB_signed_o;
  logic                     mul_ready_i;
  logic                     mul_v_i;
  logic [rw_lp-1:0]         mul_result_i;
  logic                     mul_yumi_o;
`ifdef BSG_MUL_SCHED_PERF_CNT_EN
  logic [31:0]              perf_ops, perf_busy;
`endif

  always #5 clk_i = ~clk_i;

  bsg_mul_iterative_scheduler #(.els_p(els_lp), .width_p(w_lp), .full_sized_p(1)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .req_v_i          (req_v_i),
    .req_ready_o      (req_ready_o),
    .req_opA_i        (req_opA_i),
    .req_opB_i        (req_opB_i),
    .req_opA_signed_i (req_opA_signed_i),
    .req_opB_signed_i (req_opB_signed_i),
    .res_v_o          (res_v_o),
    .res_data_o       (res_data_o),
    .res_yumi_i       (res_yumi_i),
    .mul_v_o          (mul_v_o),
    .mul_opA_o        (mul_opA_o),
    .mul_opB_o        (mul_opB_o),
    .mul_opA_signed_o (mul_opA_signed_o),
    .mul_opB_signed_o (mul_opB_signed_o),
    .mul_ready_i      (mul_ready_i),
    .mul_v_i          (mul_v_i),
    .mul_result_i     (mul_result_i),
    .mul_yumi_o       (mul_yumi_o)
`ifdef BSG_MUL_SCHED_PERF_CNT_EN
    ,
    .perf_ops_o       (perf_ops),
    .perf_busy_o      (perf_busy)
`endif
  );

  typedef struct {
    int          tag;
    logic [63:0] prod;
  } exp_t;

  exp_t        sb_q[$];
  int          obs_grants[$];
  int          vectors     = 0;
  int          miscompares = 0;

  // requester state
  bit          pend[els_lp];
  logic [31:0] pa[els_lp], pb[els_lp];
  bit          psa[els_lp], psb[els_lp];

  // reference model of the scheduler
  int          rr_m   = 0;
  bit          busy_m = 1'b0;
  int          tag_m  = 0;

  // bench-side multiplier
  bit          mm_busy = 1'b0;
  int          mm_lat  = 0;
  logic [63:0] mm_res  = '0;

  // stimulus knobs
  int          req_pct = 0, withdraw_pct = 0, ready_pct = 100, yumi_mode = 3, lat_max = 3;

  function automatic logic [63:0] mulref(logic [31:0] a, logic [31:0] b, logic sa, logic sb);
    logic [63:0] ae, be;
    ae = sa ? {{32{a[31]}}, a} : {32'b0, a};
    be = sb ? {{32{b[31]}}, b} : {32'b0, b};
    return ae * be;
  endfunction

  function automatic logic [3:0] onehot(int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet(string name);
    check({name, "_req_ready"}, 64'(req_ready_o), 64'd0);
    check({name, "_res_v"},     64'(res_v_o),     64'd0);
    check({name, "_mul_v"},     64'(mul_v_o),     64'd0);
    check({name, "_mul_yumi"},  64'(mul_yumi_o),  64'd0);
  endtask

  task automatic post_req(int i, logic [31:0] a, logic [31:0] b, bit sa, bit sb);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    psa[i]  = sa;
    psb[i]  = sb;
  endtask

  task automatic model_reset();
    for (int i = 0; i < els_lp; i++) pend[i] = 1'b0;
    rr_m    = 0;
    busy_m  = 1'b0;
    tag_m   = 0;
    mm_busy = 1'b0;
    mm_lat  = 0;
    sb_q.delete();
  endtask

  // One clock cycle: drive at negedge, predict and compare at negedge+1, advance model at posedge.
  task automatic step();
    logic [3:0]  exp_ready, exp_resv;
    logic        exp_yumi, any_v, issue;
    logic [63:0] mm_next;
    int          w;
    exp_yumi = 1'b0;
    mm_next  = '0;
    @(negedge clk_i);
    for (int i = 0; i < els_lp; i++) begin
      if (pend[i] && ($urandom_range(99) < 32'(withdraw_pct)))
        pend[i] = 1'b0;
      else if (!pend[i] && ($urandom_range(99) < 32'(req_pct)))
        post_req(i, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    for (int i = 0; i < els_lp; i++) begin
      req_v_i[i]                  = pend[i];
      req_opA_i[i*w_lp +: w_lp]   = pa[i];
      req_opB_i[i*w_lp +: w_lp]   = pb[i];
      req_opA_signed_i[i]         = psa[i];
      req_opB_signed_i[i]         = psb[i];
    end
    mul_ready_i  = ($urandom_range(99) < 32'(ready_pct));
    mul_v_i      = mm_busy && (mm_lat == 0);
    mul_result_i = mul_v_i ? mm_res : {$urandom, $urandom};
    case (yumi_mode)
      0:       res_yumi_i = 4'($urandom_range(15));
      1:       res_yumi_i = 4'b0000;
      2:       res_yumi_i = 4'($urandom_range(15)) & ~onehot(tag_m);
      default: res_yumi_i = onehot(tag_m);
    endcase
    #1;
    any_v = 1'b0;
    w     = 0;
    for (int k = els_lp-1; k >= 0; k--) begin
      if (pend[(rr_m+k) % els_lp]) begin
        w     = (rr_m+k) % els_lp;
        any_v = 1'b1;
      end
    end
    issue = !busy_m && any_v && mul_ready_i;
    for (int i = 0; i < els_lp; i++)
      if (req_ready_o[i]) obs_grants.push_back(i);
    if (!busy_m) begin
      exp_ready = issue ? onehot(w) : 4'b0000;
      check("req_ready", 64'(req_ready_o), 64'(exp_ready));
      check("mul_v",     64'(mul_v_o),     64'(any_v));
      check("res_v_idle",    64'(res_v_o),    64'd0);
      check("mul_yumi_idle", 64'(mul_yumi_o), 64'd0);
      if (any_v) begin
        check("mul_opA",        64'(mul_opA_o),        64'(pa[w]));
        check("mul_opB",        64'(mul_opB_o),        64'(pb[w]));
        check("mul_opA_signed", 64'(mul_opA_signed_o), 64'(psa[w]));
        check("mul_opB_signed", 64'(mul_opB_signed_o), 64'(psb[w]));
      end
      if (issue) mm_next = mulref(mul_opA_o, mul_opB_o, mul_opA_signed_o, mul_opB_signed_o);
    end else begin
      exp_yumi = mul_v_i && res_yumi_i[tag_m];
      exp_resv = mul_v_i ? onehot(tag_m) : 4'b0000;
      check("req_ready_busy", 64'(req_ready_o), 64'd0);
      check("mul_v_busy",     64'(mul_v_o),     64'd0);
      check("res_v_busy",     64'(res_v_o),     64'(exp_resv));
      check("mul_yumi",       64'(mul_yumi_o),  64'(exp_yumi));
    end
    @(posedge clk_i);
    if (issue) begin
      sb_q.push_back(exp_t'{tag: w, prod: mulref(pa[w], pb[w], psa[w], psb[w])});
      pend[w] = 1'b0;
      rr_m    = (w + 1) % els_lp;
      busy_m  = 1'b1;
      tag_m   = w;
      mm_busy = 1'b1;
      mm_lat  = int'($urandom_range(lat_max));
      mm_res  = mm_next;
    end else if (busy_m && exp_yumi) begin
      busy_m  = 1'b0;
      mm_busy = 1'b0;
    end else if (mm_busy && mm_lat > 0) begin
      mm_lat--;
    end
  endtask

  // Result monitor: every presented result must match the oldest issued operation.
  always @(negedge clk_i) begin
    #2;
    if (!reset_i && res_v_o != 4'b0000) begin
      if (sb_q.size() == 0) begin
        check("res_unexpected", 64'(res_v_o), 64'd0);
      end else begin
        check("res_v",    64'(res_v_o), 64'(onehot(sb_q[0].tag)));
        check("res_data", res_data_o,   sb_q[0].prod);
        if (res_yumi_i[sb_q[0].tag]) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_i          = 1'b1;
    req_v_i          = 4'hF;
    req_opA_i        = '0;
    req_opB_i        = '0;
    req_opA_signed_i = '0;
    req_opB_signed_i = '0;
    res_yumi_i       = 4'hF;
    mul_ready_i      = 1'b1;
    mul_v_i          = 1'b1;
    mul_result_i     = '0;
    #3;
    check_quiet("por");
    @(negedge clk_i);
    req_v_i    = '0;
    mul_v_i    = 1'b0;
    res_yumi_i = '0;
    @(negedge clk_i);
    reset_i = 1'b0;

    // single signed request from requester 2: 7 * -3
    post_req(2, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1);
    obs_grants.delete();
    for (int n = 0; n < 10; n++) step();
    check("single_grant_cnt", 64'(obs_grants.size()), 64'd1);
    check("single_done",      64'(sb_q.size()),       64'd0);

    // backpressure: result held with no consume while another requester waits
    lat_max   = 0;
    yumi_mode = 1;
    post_req(0, $urandom, $urandom, 1'b0, 1'b1);
    step();
    post_req(1, $urandom, $urandom, 1'b1, 1'b0);
    for (int n = 0; n < 7; n++) step();
    yumi_mode = 3;
    for (int n = 0; n < 8; n++) step();

    // wrong-consumer yumi bits are ignored
    yumi_mode = 2;
    post_req(1, $urandom, $urandom, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) step();
    yumi_mode = 3;
    for (int n = 0; n < 6; n++) step();

    // reset in the middle of an outstanding operation
    yumi_mode = 1;
    post_req(2, $urandom, $urandom, 1'b1, 1'b1);
    for (int n = 0; n < 3; n++) step();
    check("pre_reset_busy", 64'(mul_v_o), 64'd0);
    #2;
    reset_i     = 1'b1;
    req_v_i     = 4'hF;
    mul_ready_i = 1'b1;
    mul_v_i     = 1'b1;
    res_yumi_i  = 4'hF;
    #1;
    check_quiet("reset_mid");
    model_reset();
    @(negedge clk_i);
    #1;
    check_quiet("reset_hold");
    @(negedge clk_i);
    reset_i    = 1'b0;
    req_v_i    = '0;
    mul_v_i    = 1'b0;
    res_yumi_i = '0;
    yumi_mode  = 3;
    obs_grants.delete();
    post_req(3, $urandom, $urandom, 1'b0, 1'b1);
    step();
    check("post_reset_grant_cnt", 64'(obs_grants.size()), 64'd1);
    if (obs_grants.size() > 0) check("post_reset_grant", 64'(obs_grants[0]), 64'd3);
    for (int n = 0; n < 6; n++) step();

    // full contention: grants rotate 0,1,2,3,0,...
    obs_grants.delete();
    req_pct = 100;
    lat_max = 2;
    for (int n = 0; n < 80 && obs_grants.size() < 8; n++) step();
    check("contention_grants", 64'(obs_grants.size()), 64'd8);
    for (int i = 0; i < obs_grants.size(); i++)
      check("contention_order", 64'(obs_grants[i]), 64'(i % els_lp));

    // randomized traffic
    req_pct      = 40;
    withdraw_pct = 5;
    ready_pct    = 75;
    yumi_mode    = 0;
    lat_max      = 4;
    for (int n = 0; n < 3000; n++) step();

    // drain
    req_pct      = 0;
    withdraw_pct = 0;
    ready_pct    = 100;
    yumi_mode    = 3;
    for (int n = 0; n < 30; n++) step();
    check("drain_queue", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
